// File: rtl/rbl_acc.sv
// Bit-serial CIM read-side collector: shift-adds one partial-sum bit-plane per beat into
// NCOL signed lane accumulators, then holds the result under a valid/ready handoff.
module rbl_acc #(
    parameter int NCOL   = 4,
    parameter int PSUM_W = 4,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    inwidth,
    input  logic                    xsigned,
    input  logic                    psum_vld,
    input  logic [NCOL*PSUM_W-1:0]  psum,
    output logic                    busy,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [NCOL*ACC_W-1:0]   acc_out,
    output logic [4:0]              beat_cnt,
    output logic                    proto_err
);

    if (ACC_W < PSUM_W + 25) begin : g_acc_w_check
        $error("rbl_acc: ACC_W must be >= PSUM_W+25");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_inwidth;
    logic                     r_xsigned;
    logic [4:0]               r_beat_cnt;
    logic                     r_proto_err;
    logic signed [ACC_W-1:0]  r_acc [NCOL];

    logic                     w_take;
    logic                     w_beat;
    logic                     w_err;
    logic                     w_last;

    // Beat 0 seeds the lane (negated when X is two's complement: the MSB plane weighs -2^(N-1)).
    function automatic logic signed [ACC_W-1:0] f_beat(
        input logic signed [ACC_W-1:0] acc,
        input logic [PSUM_W-1:0]       p,
        input logic                    first,
        input logic                    neg
    );
        logic signed [ACC_W-1:0] z;
        z = signed'({{(ACC_W-PSUM_W){1'b0}}, p});
        if (first)
            return neg ? -z : z;
        return (acc <<< 1) + z;
    endfunction

    assign w_last = (r_beat_cnt == (r_inwidth ? 5'd23 : 5'd11));

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_beat      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psum_vld)
                    w_err = 1'b1;
                if (start) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (start)
                    w_err = 1'b1;
                if (psum_vld) begin
                    w_beat = 1'b1;
                    if (w_last)
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (psum_vld)
                    w_err = 1'b1;
                if (out_rdy) begin
                    if (start) begin
                        w_take      = 1'b1;
                        w_state_nxt = S_ACC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (start) begin
                    w_err = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_inwidth   <= 1'b0;
            r_xsigned   <= 1'b0;
            r_beat_cnt  <= 5'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err)
                r_proto_err <= 1'b1;
            if (w_take) begin
                r_inwidth  <= inwidth;
                r_xsigned  <= xsigned;
                r_beat_cnt <= 5'd0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOL; i++) begin
            if (!rstn || w_take)
                r_acc[i] <= '0;
            else if (w_beat)
                r_acc[i] <= f_beat(r_acc[i], psum[i*PSUM_W +: PSUM_W],
                                   r_beat_cnt == 5'd0, r_xsigned);
        end
    end

    for (genvar g = 0; g < NCOL; g++) begin : g_out
        assign acc_out[g*ACC_W +: ACC_W] = r_acc[g];
    end

    assign busy      = (r_state != S_IDLE);
    assign out_vld   = (r_state == S_DONE);
    assign beat_cnt  = r_beat_cnt;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_rbl_acc.sv
// Self-checking bench for rbl_acc: directed scenarios plus randomized ops against a
// weighted-sum reference model of the bit-serial accumulation.
module tb_rbl_acc;
    localparam int NCOL   = 4;
    localparam int PSUM_W = 4;
    localparam int ACC_W  = 32;
    localparam int PW     = NCOL * PSUM_W;
    localparam int AW     = NCOL * ACC_W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          inwidth = 1'b0;
    logic          xsigned = 1'b0;
    logic          psum_vld = 1'b0;
    logic [PW-1:0] psum = '0;
    logic          out_rdy = 1'b0;
    logic          busy;
    logic          out_vld;
    logic [AW-1:0] acc_out;
    logic [4:0]    beat_cnt;
    logic          proto_err;

    int n_chk  = 0;
    int n_fail = 0;

    rbl_acc #(.NCOL(NCOL), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .inwidth(inwidth), .xsigned(xsigned),
        .psum_vld(psum_vld), .psum(psum), .busy(busy), .out_vld(out_vld),
        .out_rdy(out_rdy), .acc_out(acc_out), .beat_cnt(beat_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode, latched op settings, and the list of beats received this op.
    int            m_mode = 0;   // 0 idle, 1 accumulating, 2 result held
    int            m_n = 12;
    bit            m_xs = 1'b0;
    bit            m_err = 1'b0;
    bit            m_init = 1'b0;
    logic [PW-1:0] mq[$];

    // Lane value = sum of beat_j * 2^(m-1-j), the first beat negative for signed X.
    function automatic longint lane_val(input int ln);
        longint v = 0;
        longint t;
        int m = mq.size();
        logic [PW-1:0] w;
        for (int j = 0; j < m; j++) begin
            w = mq[j];
            t = longint'(w[ln*PSUM_W +: PSUM_W]) <<< (m - 1 - j);
            if (j == 0 && m_xs)
                t = -t;
            v += t;
        end
        return v;
    endfunction

    task automatic m_latch();
        m_n  = inwidth ? 24 : 12;
        m_xs = xsigned;
        mq.delete();
        m_mode = 1;
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            m_mode = 0; m_n = 12; m_xs = 1'b0; m_err = 1'b0; mq.delete(); m_init = 1'b1;
        end else begin
            case (m_mode)
                0: begin
                    if (psum_vld) m_err = 1'b1;
                    if (start) m_latch();
                end
                1: begin
                    if (start) m_err = 1'b1;
                    if (psum_vld) begin
                        mq.push_back(psum);
                        if (mq.size() == m_n) m_mode = 2;
                    end
                end
                default: begin
                    if (psum_vld) m_err = 1'b1;
                    if (out_rdy) begin
                        if (start) m_latch();
                        else m_mode = 0;
                    end else if (start) begin
                        m_err = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic [AW-1:0] e;
        longint lv;
        if (m_init) begin
            for (int i = 0; i < NCOL; i++) begin
                lv = lane_val(i);
                e[i*ACC_W +: ACC_W] = lv[ACC_W-1:0];
            end
            chk("busy",      128'(busy),      128'(m_mode != 0));
            chk("out_vld",   128'(out_vld),   128'(m_mode == 2));
            chk("beat_cnt",  128'(beat_cnt),  128'(mq.size()));
            chk("proto_err", 128'(proto_err), 128'(m_err));
            chk("acc_out",   128'(acc_out),   128'(e));
        end
    end

    task automatic cyc(input bit st, input bit pv, input logic [PW-1:0] p, input bit rdy);
        @(negedge clk);
        start = st; psum_vld = pv; psum = p; out_rdy = rdy;
        inwidth = 1'($urandom); xsigned = 1'($urandom);
    endtask

    task automatic go(input bit w, input bit xs, input bit rdy);
        @(negedge clk);
        start = 1'b1; inwidth = w; xsigned = xs; psum_vld = 1'b0; out_rdy = rdy;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; psum_vld = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic chk_lanes(input string nm, input logic [ACC_W-1:0] v);
        chk(nm, 128'(acc_out), 128'({NCOL{v}}));
    endtask

    task automatic handshake();
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 0);
        chk("hs out_vld", 128'(out_vld), 128'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit w;
        bit b2b;
        int sent;
        int n;

        // Reset state
        @(negedge clk);
        rstn = 1'b1;
        chk("rst busy",      128'(busy),      128'(0));
        chk("rst out_vld",   128'(out_vld),   128'(0));
        chk("rst acc_out",   128'(acc_out),   128'(0));
        chk("rst beat_cnt",  128'(beat_cnt),  128'(0));
        chk("rst proto_err", 128'(proto_err), 128'(0));

        // T1: unsigned 12-bit, all ones
        go(0, 0, 0);
        repeat (12) cyc(0, 1, 16'h1111, 0);
        chk("T1 vld before latency", 128'(out_vld), 128'(0));
        cyc(0, 0, '0, 0);
        chk("T1 out_vld", 128'(out_vld), 128'(1));
        chk_lanes("T1 acc", 32'd4095);
        chk("T1 beat_cnt", 128'(beat_cnt), 128'(12));
        handshake();
        chk_lanes("T1 acc held in idle", 32'd4095);
        chk("T1 busy idle", 128'(busy), 128'(0));

        // T2: signed X, only MSB plane set
        go(0, 1, 0);
        cyc(0, 1, 16'h1111, 0);
        repeat (11) cyc(0, 1, 16'h0000, 0);
        cyc(0, 0, '0, 0);
        chk("T2 out_vld", 128'(out_vld), 128'(1));
        chk_lanes("T2 acc", 32'hFFFFF800);
        handshake();

        // T3: 24 beats of 15 with stalls
        go(1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            if (i == 3 || i == 9 || i == 17) cyc(0, 0, '0, 0);
            cyc(0, 1, 16'hFFFF, 0);
        end
        cyc(0, 0, '0, 0);
        chk_lanes("T3 acc", 32'd251658225);
        chk("T3 beat_cnt", 128'(beat_cnt), 128'(24));
        handshake();

        // T4: hold in DONE with a stray beat
        go(0, 0, 0);
        repeat (12) cyc(0, 1, 16'h2222, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, i == 2, 16'h5555, 0);
            chk("T4 out_vld held", 128'(out_vld), 128'(1));
            chk_lanes("T4 acc stable", 32'd8190);
        end
        chk("T4 proto_err", 128'(proto_err), 128'(1));
        handshake();
        chk("T4 busy", 128'(busy), 128'(0));

        // T5: back-to-back handoff
        rst_pulse();
        go(0, 0, 0);
        repeat (12) cyc(0, 1, 16'h1111, 0);
        cyc(0, 0, '0, 0);
        chk_lanes("T5 first acc", 32'd4095);
        go(0, 1, 1);
        cyc(0, 1, 16'h0000, 0);
        chk("T5 out_vld gap", 128'(out_vld), 128'(0));
        chk("T5 busy", 128'(busy), 128'(1));
        chk("T5 cleared", 128'(acc_out), 128'(0));
        repeat (11) cyc(0, 1, 16'h1111, 0);
        cyc(0, 0, '0, 0);
        chk("T5 out_vld", 128'(out_vld), 128'(1));
        chk_lanes("T5 acc", 32'd2047);
        chk("T5 proto_err", 128'(proto_err), 128'(0));
        handshake();

        // T6: reset mid-op, then fresh op
        go(0, 0, 0);
        repeat (6) cyc(0, 1, 16'h3333, 0);
        rst_pulse();
        chk("T6 busy",     128'(busy),     128'(0));
        chk("T6 out_vld",  128'(out_vld),  128'(0));
        chk("T6 acc",      128'(acc_out),  128'(0));
        chk("T6 beat_cnt", 128'(beat_cnt), 128'(0));
        go(0, 0, 0);
        repeat (12) cyc(0, 1, 16'h1111, 0);
        cyc(0, 0, '0, 0);
        chk_lanes("T6 fresh acc", 32'd4095);
        handshake();

        // Randomized ops against the model
        rst_pulse();
        b2b = 1'b0;
        w = 1'b0;
        for (int op = 0; op < 30; op++) begin
            if (!b2b) begin
                w = 1'($urandom);
                go(w, 1'($urandom), 0);
            end
            n = w ? 24 : 12;
            sent = 0;
            while (sent < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    cyc($urandom_range(0, 7) == 0, 0, PW'($urandom), 0);
                end else begin
                    cyc(0, 1, PW'($urandom), 0);
                    sent++;
                end
            end
            repeat ($urandom_range(0, 3))
                cyc($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, PW'($urandom), 0);
            if ($urandom_range(0, 2) == 0) begin
                w = 1'($urandom);
                go(w, 1'($urandom), 1);
                b2b = 1'b1;
            end else begin
                cyc(0, 0, '0, 1);
                b2b = 1'b0;
            end
        end
        repeat (3) cyc(0, 0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
